// File: rtl/alu_pkg.sv
// Shared types for the iterative execute unit: opcodes, FSM states, opcode classifiers.
// Build option: define ALU_DIV_EN to include the divide/remainder datapath.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND   = 4'd0,
      OP_OR    = 4'd1,
      OP_XOR   = 4'd2,
      OP_ADD   = 4'd3,
      OP_SUB   = 4'd4,
      OP_SLL   = 4'd5,
      OP_SRL   = 4'd6,
      OP_SRA   = 4'd7,
      OP_SLT   = 4'd8,
      OP_SLTU  = 4'd9,
      OP_MUL   = 4'd10,
      OP_MULHU = 4'd11,
      OP_DIV   = 4'd12,
      OP_DIVU  = 4'd13,
      OP_REM   = 4'd14,
      OP_REMU  = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic is_div_op(input alu_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

   // Divide opcodes only become multi-cycle when the divider is built in.
   function automatic logic is_iter_op(input alu_op_e op);
`ifdef ALU_DIV_EN
      return (op == OP_MUL) || (op == OP_MULHU) || is_div_op(op);
`else
      return (op == OP_MUL) || (op == OP_MULHU);
`endif
   endfunction

endpackage

// File: rtl/iter_muldiv_core.sv
// XLEN-step shift-add multiplier and restoring divider sharing one 2*XLEN accumulator.
// Build option: ALU_DIV_EN adds the divider; without it only MUL/MULHU are handled.
module iter_muldiv_core
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  alu_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(XLEN);

   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] acc_step;
   logic [2*XLEN-1:0] mul_step;
   logic [XLEN:0]     mul_sum;
   logic [XLEN-1:0]   addend;
   logic [CNT_W-1:0]  count;
   logic              busy;
   logic              want_hi;

`ifdef ALU_DIV_EN
   logic              div_op, want_rem, neg_q, neg_r, div_zero;
   logic              sgn_op, a_neg, b_neg;
   logic [XLEN-1:0]   dividend, a_mag, b_mag, quot, rem;
   logic [XLEN:0]     diff;
   logic [2*XLEN-1:0] div_step;
`endif

   // Multiplier: {hi,lo} starts as {0,multiplier}; add multiplicand into hi when lo[0] set, then shift right.
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, addend} : '0);
      mul_step = {mul_sum, acc[XLEN-1:1]};
   end

`ifdef ALU_DIV_EN
   // Divider works on magnitudes; {rem,quot} starts as {0,|dividend|} and shifts left one bit per step.
   always_comb begin
      sgn_op   = (op == OP_DIV) || (op == OP_REM);
      a_neg    = sgn_op & a[XLEN-1];
      b_neg    = sgn_op & b[XLEN-1];
      a_mag    = a_neg ? '0 - a : a;
      b_mag    = b_neg ? '0 - b : b;
      diff     = acc[2*XLEN-1:XLEN-1] - {1'b0, addend};
      div_step = diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      acc_step = div_op ? div_step : mul_step;
   end
`else
   assign acc_step = mul_step;
`endif

   // Result is taken from the final step's value so it can be registered on the same edge as done.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      result = want_hi ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
`ifdef ALU_DIV_EN
      quot = acc_step[XLEN-1:0];
      rem  = acc_step[2*XLEN-1:XLEN];
      if (div_op) begin
         if (div_zero)
            result = want_rem ? dividend : '1;
         else if (want_rem)
            result = neg_r ? '0 - rem : rem;
         else
            result = neg_q ? '0 - quot : quot;
      end
`endif
   end

   assign done = busy && (count == '0);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (rst) begin
         acc     <= '0;
         addend  <= '0;
         count   <= '0;
         busy    <= 1'b0;
         want_hi <= 1'b0;
`ifdef ALU_DIV_EN
         div_op   <= 1'b0;
         want_rem <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         dividend <= '0;
`endif
      end else if (start) begin
         busy    <= 1'b1;
         count   <= CNT_W'(XLEN - 1);
         want_hi <= (op == OP_MULHU);
         acc     <= {{XLEN{1'b0}}, b};
         addend  <= a;
`ifdef ALU_DIV_EN
         div_op   <= is_div_op(op);
         want_rem <= (op == OP_REM) || (op == OP_REMU);
         neg_q    <= a_neg ^ b_neg;
         neg_r    <= a_neg;
         div_zero <= (b == '0);
         dividend <= a;
         if (is_div_op(op)) begin
            acc    <= {{XLEN{1'b0}}, a_mag};
            addend <= b_mag;
         end
`endif
      end else if (busy) begin
         acc <= acc_step;
         if (count == '0)
            busy <= 1'b0;
         else
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/iter_alu.sv
// EX-stage ALU: registered single-cycle ops, iterative mul/div, valid/ready on both sides.
// Build option: ALU_DIV_EN enables divide/remainder; otherwise opcodes 12-15 return 0 with illegal_o.
module iter_alu
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [3:0]      ALUCtrl_i,
   input  logic [XLEN-1:0] ALUin1_i,
   input  logic [XLEN-1:0] ALUin2_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] ALUResult_o,
   output logic            illegal_o
);

   localparam int SHAMT_W = $clog2(XLEN);

   state_e            state, next_state;
   alu_op_e           op;
   logic              accept, iter_op, core_done, op_illegal;
   logic [SHAMT_W-1:0] shamt;
   logic [XLEN-1:0]   alu_result, core_result, result_q;
   logic              illegal_q;

   assign op      = alu_op_e'(ALUCtrl_i);
   assign shamt   = ALUin2_i[SHAMT_W-1:0];
   assign iter_op = is_iter_op(op);

   // In DONE, readiness follows the consumer so a result handoff and a new accept share one cycle.
   assign in_ready_o  = (state == IDLE) || ((state == DONE) && out_ready_i);
   assign out_valid_o = (state == DONE);
   assign accept      = in_valid_i && in_ready_o;

   iter_muldiv_core #(.XLEN(XLEN)) u_core (
      .clk    (clk_i),
      .rst    (rst_i),
      .start  (accept && iter_op),
      .op     (op),
      .a      (ALUin1_i),
      .b      (ALUin2_i),
      .done   (core_done),
      .result (core_result)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept) next_state = iter_op ? BUSY : DONE;
         BUSY: if (core_done) next_state = DONE;
         DONE: begin
            if (accept)           next_state = iter_op ? BUSY : DONE;
            else if (out_ready_i) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      alu_result = '0;
      op_illegal = 1'b0;
      case (op)
         OP_AND:  alu_result = ALUin1_i & ALUin2_i;
         OP_OR:   alu_result = ALUin1_i | ALUin2_i;
         OP_XOR:  alu_result = ALUin1_i ^ ALUin2_i;
         OP_ADD:  alu_result = ALUin1_i + ALUin2_i;
         OP_SUB:  alu_result = ALUin1_i - ALUin2_i;
         OP_SLL:  alu_result = ALUin1_i << shamt;
         OP_SRL:  alu_result = ALUin1_i >> shamt;
         OP_SRA:  alu_result = XLEN'($signed(ALUin1_i) >>> shamt);
         OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(ALUin1_i) < $signed(ALUin2_i)};
         OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, ALUin1_i < ALUin2_i};
         default: alu_result = '0;
      endcase
`ifndef ALU_DIV_EN
      op_illegal = is_div_op(op);
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         result_q  <= '0;
         illegal_q <= 1'b0;
      end else if (accept && !iter_op) begin
         result_q  <= alu_result;
         illegal_q <= op_illegal;
      end else if ((state == BUSY) && core_done) begin
         result_q  <= core_result;
         illegal_q <= 1'b0;
      end
   end

   assign ALUResult_o = result_q;
   assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu (XLEN=32); covers both ALU_DIV_EN builds.
module tb_iter_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, illegal;
   logic [3:0]  ctrl;
   logic [31:0] in1, in2, result;

   int total = 0;
   int bad   = 0;

   logic [31:0] res;
   logic        ill;
   int          lat;

   iter_alu #(.XLEN(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .ALUCtrl_i   (ctrl),
      .ALUin1_i    (in1),
      .ALUin2_i    (in2),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .ALUResult_o (result),
      .illegal_o   (illegal)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      ctrl     = op;
      in1      = a;
      in2      = b;
   endtask

   // Issue one op from IDLE, wait (bounded) for the result, capture it, then hand it off.
   task automatic do_op(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic il, output int cycles);
      drive(op, a, b);
      step();
      in_valid = 1'b0;
      cycles   = 1;
      while (!out_valid && cycles < 100) begin
         step();
         cycles++;
      end
      r  = result;
      il = illegal;
      step();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ctrl      = 4'd0;
      in1       = '0;
      in2       = '0;
      repeat (2) step();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_result",    result,             32'd0);
      check("rst_illegal",   {31'd0, illegal},   32'd0);
      rst = 1'b0;

      // Back-to-back single-cycle ops with the consumer always ready.
      drive(OP_ADD, 32'hFFFF_FFFF, 32'd1);
      step();
      check("add_valid",  {31'd0, out_valid}, 32'd1);
      check("add_result", result,             32'h0000_0000);
      check("add_ready",  {31'd0, in_ready},  32'd1);
      drive(OP_SRA, 32'h8000_0000, 32'h0000_0024);
      step();
      in_valid = 1'b0;
      check("sra_valid",  {31'd0, out_valid}, 32'd1);
      check("sra_result", result,             32'hF800_0000);
      step();
      check("b2b_drain_valid", {31'd0, out_valid}, 32'd0);

      do_op(OP_SUB, 32'd0, 32'd1, res, ill, lat);
      check("sub_wrap", res, 32'hFFFF_FFFF);
      check("sub_lat",  lat, 1);
      do_op(OP_SLL, 32'h0000_0001, 32'hFFFF_FFFF, res, ill, lat);
      check("sll_shamt31", res, 32'h8000_0000);
      do_op(OP_SRL, 32'h8000_0000, 32'd4, res, ill, lat);
      check("srl_zero_fill", res, 32'h0800_0000);
      do_op(OP_SLTU, 32'd1, 32'hFFFF_FFFF, res, ill, lat);
      check("sltu", res, 32'd1);
      do_op(OP_SLT, 32'd1, 32'hFFFF_FFFF, res, ill, lat);
      check("slt_signed", res, 32'd0);
      do_op(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, res, ill, lat);
      check("or", res, 32'hF0F0_0F0F);

      // Multiply results and fixed latency.
      do_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, res, ill, lat);
      check("mul_lo",      res, 32'h0000_0000);
      check("mul_lat",     lat, 33);
      check("mul_illegal", {31'd0, ill}, 32'd0);
      do_op(OP_MULHU, 32'h0001_0000, 32'h0001_0000, res, ill, lat);
      check("mulhu",     res, 32'h0000_0001);
      check("mulhu_lat", lat, 33);
      do_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, ill, lat);
      check("mul_max_lo", res, 32'h0000_0001);
      do_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, ill, lat);
      check("mulhu_max", res, 32'hFFFF_FFFE);
      do_op(OP_MUL, 32'd3, 32'd5, res, ill, lat);
      check("mul_small", res, 32'd15);

      // Backpressure: result held, new request ignored while the consumer stalls.
      out_ready = 1'b0;
      drive(OP_SLT, 32'hFFFF_FFFB, 32'd3);
      step();
      drive(OP_ADD, 32'd1, 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid",  {31'd0, out_valid}, 32'd1);
         check("bp_ready",  {31'd0, in_ready},  32'd0);
         check("bp_result", result,             32'd1);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_drain_valid", {31'd0, out_valid}, 32'd0);

`ifdef ALU_DIV_EN
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, ill, lat);
      check("div_ovf",     res, 32'h8000_0000);
      check("div_ovf_lat", lat, 33);
      check("div_illegal", {31'd0, ill}, 32'd0);
      do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, ill, lat);
      check("rem_ovf", res, 32'h0000_0000);
      do_op(OP_DIVU, 32'd7, 32'd0, res, ill, lat);
      check("divu_zero",     res, 32'hFFFF_FFFF);
      check("divu_zero_lat", lat, 33);
      do_op(OP_REMU, 32'd7, 32'd0, res, ill, lat);
      check("remu_zero", res, 32'd7);
      do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, res, ill, lat);
      check("div_neg", res, 32'hFFFF_FFFD);
      do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, res, ill, lat);
      check("rem_neg", res, 32'hFFFF_FFFF);
      do_op(OP_DIVU, 32'd100, 32'd7, res, ill, lat);
      check("divu", res, 32'd14);
`else
      do_op(OP_DIV, 32'd10, 32'd2, res, ill, lat);
      check("div_absent_result",  res, 32'd0);
      check("div_absent_illegal", {31'd0, ill}, 32'd1);
      check("div_absent_lat",     lat, 1);
      do_op(OP_XOR, 32'h0000_00F0, 32'h0000_00FF, res, ill, lat);
      check("xor_result",  res, 32'h0000_000F);
      check("xor_illegal", {31'd0, ill}, 32'd0);
`endif

      // Reset in the middle of an iterative op, then confirm the unit still works.
`ifdef ALU_DIV_EN
      drive(OP_DIV, 32'd1000, 32'd3);
`else
      drive(OP_MUL, 32'd1000, 32'd3);
`endif
      step();
      in_valid = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      check("midrst_valid",   {31'd0, out_valid}, 32'd0);
      check("midrst_ready",   {31'd0, in_ready},  32'd1);
      check("midrst_result",  result,             32'd0);
      check("midrst_illegal", {31'd0, illegal},   32'd0);
      rst = 1'b0;
      do_op(OP_MUL, 32'd6, 32'd7, res, ill, lat);
      check("post_rst_mul",     res, 32'd42);
      check("post_rst_mul_lat", lat, 33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
